// File: rtl/clk_div_checker.sv
// clk_div_checker: measures period and high time of a clk-synchronous
// divided clock, tracks lock against expected values, flags stuck input.

module clk_div_checker #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 6,
    parameter int EXP_HIGH   = 3,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_clk,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_cnt,
    output logic             stuck
);

    localparam int MC_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] EXP_P   = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] EXP_H   = CNT_W'(EXP_HIGH);
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
    localparam logic [MC_W-1:0]  LC      = MC_W'(LOCK_CNT);
    localparam logic [MC_W-1:0]  LC_M1   = MC_W'(LOCK_CNT - 1);

    typedef enum logic {
        SYNC,
        RUN
    } state_t;

    state_t           state;
    logic             div_q;
    logic             rise;
    logic             fall;
    logic             match;
    logic             tmo;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cap;
    logic [MC_W-1:0]  match_cnt;

    assign rise  = div_clk & ~div_q;
    assign fall  = ~div_clk & div_q;
    assign match = (per_cnt == EXP_P) && (hi_cap == EXP_H);
    // A rise landing exactly on the limit is a valid edge, not a timeout
    assign tmo   = !rise && (per_cnt == TMO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SYNC;
            div_q      <= 1'b0;
            per_cnt    <= '0;
            hi_cap     <= '0;
            match_cnt  <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
            stuck      <= 1'b0;
        end else begin
            div_q      <= div_clk;
            meas_valid <= 1'b0;
            err        <= 1'b0;

            if (rise) begin
                per_cnt <= CNT_ONE;
            end else if (per_cnt != CNT_MAX) begin
                per_cnt <= per_cnt + 1'b1;
            end

            // High time shares the since-rise counter, latched at the fall
            if (fall) begin
                hi_cap <= per_cnt;
            end

            if (rise) begin
                stuck <= 1'b0;
                state <= RUN;
                if (state == RUN) begin
                    period     <= per_cnt;
                    high_time  <= hi_cap;
                    meas_valid <= 1'b1;
                    if (match) begin
                        if (match_cnt != LC) begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                        locked <= (match_cnt >= LC_M1);
                    end else begin
                        match_cnt <= '0;
                        locked    <= 1'b0;
                        err       <= 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end
            end else if (tmo) begin
                stuck     <= 1'b1;
                locked    <= 1'b0;
                match_cnt <= '0;
                state     <= SYNC;
                err       <= 1'b1;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule
